branch_pc_sequencer: RTL and testbench



---
 rtl/branch_pc_sequencer_pkg.sv | 14 +
 rtl/branch_pc_sequencer_if.sv | 30 +++
 rtl/branch_pc_sequencer_sat_counter.sv | 19 +
 rtl/branch_pc_sequencer.sv | 95 +++++++++
 tb/tb_branch_pc_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/branch_pc_sequencer_pkg.sv
// Shared types and constants for the branch-aware fetch PC sequencer.
package branch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } seq_state_t;

    localparam logic        BR_BEQ  = 1'b0;
    localparam logic        BR_BNE  = 1'b1;
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_pc_sequencer_if.sv
// Fetch request and branch-result channels between the sequencer and its neighbours.
interface branch_pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             fetch_ready;
    logic             fetch_valid;
    logic [31:0]      fetch_pc;
    logic             br_valid;
    logic             br_ready;
    logic             br_type;
    logic             br_zero;
    logic [31:0]      br_target;
    logic             taken;
    logic             flush;
    logic             misalign;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output fetch_ready, br_valid, br_type, br_zero, br_target,
        input  fetch_valid, fetch_pc, br_ready, taken, flush, misalign,
               branch_cnt, taken_cnt
    );

    modport slave (
        input  fetch_ready, br_valid, br_type, br_zero, br_target,
        output fetch_valid, fetch_pc, br_ready, taken, flush, misalign,
               branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_pc_sequencer_sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_pc_sequencer.sv
// Owns the fetch PC: sequential fetch, redirect on taken BEQ/BNE, then a fixed flush window.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch or branch traffic
// RUN   | fetching sequentially, accepting branch results
// FLUSH | younger instructions squashed, PC parked at redirect target
module branch_pc_sequencer
    import branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_pc_sequencer_if.slave bus
);

    seq_state_t       state;
    logic [31:0]      fetch_pc;
    logic [3:0]       flush_cnt;
    logic             taken_q;
    logic             misalign_q;
    logic             run;
    logic             br_accept;
    logic             br_taken;
    logic             fetch_fire;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    assign run        = (state == RUN);
    assign br_accept  = run && bus.br_valid;
    assign fetch_fire = run && bus.fetch_ready;
    assign br_taken   = (bus.br_type == BR_BNE) ? ~bus.br_zero : bus.br_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            fetch_pc   <= RESET_PC;
            flush_cnt  <= 4'd0;
            taken_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            taken_q <= 1'b0;
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    // Redirect wins over a same-cycle sequential increment.
                    if (br_accept && br_taken) begin
                        fetch_pc  <= {bus.br_target[31:2], 2'b00};
                        taken_q   <= 1'b1;
                        flush_cnt <= 4'(FLUSH_CYCLES);
                        state     <= FLUSH;
                        if (bus.br_target[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                        end
                    end else if (fetch_fire) begin
                        fetch_pc <= fetch_pc + PC_STEP;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 4'd1;
                    if (flush_cnt == 4'd1) begin
                        state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_accept),
        .count (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_accept && br_taken),
        .count (taken_cnt)
    );

    assign bus.fetch_valid = run;
    assign bus.br_ready    = run;
    assign bus.fetch_pc    = fetch_pc;
    assign bus.taken       = taken_q;
    assign bus.flush       = (state == FLUSH);
    assign bus.misalign    = misalign_q;
    assign bus.branch_cnt  = branch_cnt;
    assign bus.taken_cnt   = taken_cnt;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Scoreboard bench: driver predicts per-cycle outputs from a behavioural model, monitor compares.
module tb_branch_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          FC     = 2;
    localparam int          CW     = 16;
    localparam int          CMAX   = (1 << CW) - 1;

    typedef struct {
        logic        fv;
        logic        brdy;
        logic        fl;
        logic        tk;
        logic        mis;
        logic [31:0] pc;
        int          bc;
        int          tc;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    branch_pc_sequencer_if #(.CNT_W(CW)) bus ();

    branch_pc_sequencer #(
        .RESET_PC     (RST_PC),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    snap_t       snap_q[$];
    logic [31:0] fetch_q[$];
    logic [31:0] taken_q[$];

    int vectors = 0;
    int miscompares = 0;

    // reference model: cycles of boot left, flush cycles left, architectural PC
    bit          m_boot;
    int          m_flush_left;
    logic [31:0] m_pc;
    bit          m_taken_pulse;
    bit          m_mis;
    int          m_bc;
    int          m_tc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot        = 1'b1;
        m_flush_left  = 0;
        m_pc          = RST_PC;
        m_taken_pulse = 1'b0;
        m_mis         = 1'b0;
        m_bc          = 0;
        m_tc          = 0;
        taken_q.delete();
    endtask

    task automatic step(input bit rst, input bit fr, input bit bv, input bit bt,
                        input bit bz, input logic [31:0] tgt);
        snap_t s;
        bit    active;
        bit    tk;
        @(posedge clk);
        #1;
        rst_n           = ~rst;
        bus.fetch_ready = fr;
        bus.br_valid    = bv;
        bus.br_type     = bt;
        bus.br_zero     = bz;
        bus.br_target   = tgt;
        if (rst) model_reset();
        active  = !m_boot && (m_flush_left == 0);
        s.fv    = active;
        s.brdy  = active;
        s.fl    = (m_flush_left > 0);
        s.tk    = m_taken_pulse;
        s.mis   = m_mis;
        s.pc    = m_pc;
        s.bc    = m_bc;
        s.tc    = m_tc;
        snap_q.push_back(s);
        if (active && fr) fetch_q.push_back(m_pc);
        if (rst) return;
        m_taken_pulse = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else begin
            tk = 1'b0;
            if (bv) begin
                if (m_bc < CMAX) m_bc++;
                tk = bt ? !bz : bz;
            end
            if (tk) begin
                if (m_tc < CMAX) m_tc++;
                if (tgt % 4 != 0) m_mis = 1'b1;
                m_pc          = tgt - (tgt % 4);
                m_flush_left  = FC;
                m_taken_pulse = 1'b1;
                taken_q.push_back(m_pc);
            end else if (fr) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic idle(input int n, input bit fr);
        for (int i = 0; i < n; i++) step(0, fr, 0, 0, 0, 32'h0);
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(negedge clk);
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                check("fetch_valid", 32'(bus.fetch_valid), 32'(s.fv));
                check("br_ready",    32'(bus.br_ready),    32'(s.brdy));
                check("flush",       32'(bus.flush),       32'(s.fl));
                check("taken",       32'(bus.taken),       32'(s.tk));
                check("misalign",    32'(bus.misalign),    32'(s.mis));
                check("fetch_pc",    bus.fetch_pc,         s.pc);
                check("branch_cnt",  32'(bus.branch_cnt),  32'(s.bc));
                check("taken_cnt",   32'(bus.taken_cnt),   32'(s.tc));
            end
            if (bus.fetch_valid === 1'b1 && bus.fetch_ready === 1'b1) begin
                if (fetch_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL fetch_handshake: got unexpected fetch of %h expected none", bus.fetch_pc);
                end else begin
                    check("fetch_req_pc", bus.fetch_pc, fetch_q.pop_front());
                end
            end
            if (bus.taken === 1'b1) begin
                if (taken_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL taken_event: got unexpected taken pulse expected none");
                end else begin
                    check("redirect_pc", bus.fetch_pc, taken_q.pop_front());
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] tgt;
        bus.fetch_ready = 1'b0;
        bus.br_valid    = 1'b0;
        bus.br_type     = 1'b0;
        bus.br_zero     = 1'b0;
        bus.br_target   = 32'h0;
        model_reset();
        #2 rst_n = 1'b0;

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 32'h0);
        idle(5, 1);                                   // boot, then 0x0,0x4,0x8,0xC
        step(0, 1, 1, 0, 1, 32'h0000_0100);           // BEQ taken to 0x100
        idle(3, 0);
        step(0, 1, 1, 0, 1, 32'h0000_0110);           // BEQ taken 0x100 -> 0x110
        idle(3, 1);
        step(0, 0, 1, 0, 1, 32'h0000_0200);
        idle(2, 0);
        step(0, 1, 1, 1, 1, 32'h0000_01F0);           // BNE not taken -> 0x204
        idle(2, 1);
        step(0, 1, 1, 0, 1, 32'hFFFF_FFFC);
        idle(2, 0);
        step(0, 1, 0, 0, 0, 32'h0);                   // wrap to 0x0
        step(0, 0, 1, 0, 1, 32'h0000_0006);           // misaligned target
        idle(4, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 1, 32'h0000_0040);
        idle(3, 0);                                   // fetch_ready low holds PC
        step(0, 1, 1, 0, 1, 32'h0000_0080);
        step(0, 1, 0, 0, 0, 32'h0);                   // flush cycle 1
        step(1, 1, 0, 0, 0, 32'h0);                   // reset in flush cycle 2
        idle(4, 1);

        for (int i = 0; i < 600; i++) begin
            tgt = $urandom;
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(199) == 0)
                step(1, 0, 0, 0, 0, 32'h0);
            else
                step(0, $urandom_range(3) != 0, $urandom_range(2) == 0,
                     1'($urandom), 1'($urandom), tgt);
        end

        idle(4, 0);
        @(negedge clk);
        #1;
        check("snap_q_drained",  32'(snap_q.size()),  32'd0);
        check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
        check("taken_q_drained", 32'(taken_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
